// File: rtl/seq_scan_ctrl_if.sv
// Stream, job-control and status bundle for seq_scan_ctrl.
// Signal prefixes are from the controller's point of view (slave modport).
interface seq_scan_ctrl_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             i_start;
    logic [7:0]       i_num_bytes;
    logic [PAT_W-1:0] i_cfg_pattern;
    logic             i_cfg_overlap;
    logic [7:0]       i_in_data;
    logic             i_in_valid;
    logic             o_in_ready;
    logic             o_bit_out;
    logic             o_match;
    logic [CNT_W-1:0] o_match_cnt;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_num_bytes, i_cfg_pattern, i_cfg_overlap, i_in_data, i_in_valid,
        input  o_in_ready, o_bit_out, o_match, o_match_cnt, o_busy, o_done
    );

    modport slave (
        input  i_start, i_num_bytes, i_cfg_pattern, i_cfg_overlap, i_in_data, i_in_valid,
        output o_in_ready, o_bit_out, o_match, o_match_cnt, o_busy, o_done
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Byte-stream to bit-serial pattern scanner: loads bytes, shifts them MSB-first
// through a programmable Moore matcher, counts matches and flags job completion.
module seq_scan_ctrl #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    seq_scan_ctrl_if.slave s_bus
);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_bytes_left;
    logic [PAT_W-1:0]   r_pat;
    logic               r_ovl;
    logic [PAT_W-1:0]   r_win;
    logic [FILL_W-1:0]  r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_match;

    logic               w_start_acc;
    logic               w_accept;
    logic               w_shifting;
    logic [PAT_W-1:0]   w_win_nxt;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic               w_hit;

    assign w_start_acc = (r_state == StIdle) && s_bus.i_start;
    assign w_accept    = (r_state == StLoad) && s_bus.i_in_valid;
    assign w_shifting  = (r_state == StShift);

    // Matcher looks at the window/fill as they will be after this edge.
    assign w_win_nxt  = {r_win[PAT_W-2:0], r_shift[7]};
    assign w_fill_nxt = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + FILL_W'(1);
    assign w_hit      = w_shifting && (w_win_nxt == r_pat) && (w_fill_nxt == FILL_MAX);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (s_bus.i_start) begin
                    w_state_nxt = (s_bus.i_num_bytes != 8'd0) ? StLoad : StDone;
                end
            end
            StLoad: begin
                if (s_bus.i_in_valid) w_state_nxt = StShift;
            end
            StShift: begin
                if (r_bit_cnt == 3'd7) begin
                    w_state_nxt = (r_bytes_left != 8'd0) ? StLoad : StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_bytes_left <= '0;
            r_pat        <= '0;
            r_ovl        <= 1'b0;
            r_win        <= '0;
            r_fill       <= '0;
            r_cnt        <= '0;
            r_match      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_match <= w_hit;
            if (w_start_acc) begin
                r_pat        <= s_bus.i_cfg_pattern;
                r_ovl        <= s_bus.i_cfg_overlap;
                r_bytes_left <= s_bus.i_num_bytes;
                r_cnt        <= '0;
                r_win        <= '0;
                r_fill       <= '0;
            end
            if (w_accept) begin
                r_shift      <= s_bus.i_in_data;
                r_bytes_left <= r_bytes_left - 8'd1;
                r_bit_cnt    <= '0;
            end
            if (w_shifting) begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_win     <= w_win_nxt;
                // Non-overlapping mode must see a full fresh pattern after each hit.
                r_fill    <= (w_hit && !r_ovl) ? '0 : w_fill_nxt;
                if (w_hit && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign s_bus.o_in_ready  = (r_state == StLoad);
    assign s_bus.o_busy      = (r_state == StLoad) || (r_state == StShift);
    assign s_bus.o_done      = (r_state == StDone);
    assign s_bus.o_bit_out   = w_shifting && r_shift[7];
    assign s_bus.o_match     = r_match;
    assign s_bus.o_match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: a bit-string model predicts per-bit hits and
// running counts; a negedge monitor compares the DUT to it every cycle.
module tb_seq_scan_ctrl;
    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int          MAXB  = 512;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: bit stream of the job, hit flag per 1-based bit index, running count.
    logic [7:0] job_bytes[$];
    bit         m_bits[MAXB];
    bit         m_hit[MAXB+1];
    int         m_cum[MAXB+1];
    int         m_total = 0;

    bit mon_en = 1'b0;
    int n = 0;
    bit last_shift = 1'b0;
    bit zero_pend = 1'b0;
    bit mon_shift;
    bit mon_exp_done;
    int pulses = 0;
    int lo_run = 0;
    int gap_seen = 0;
    bit ready_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build_model(input logic [PAT_W-1:0] pat, input bit ovl);
        int last;
        int cnt;
        bit ok;
        m_total = job_bytes.size() * 8;
        for (int i = 0; i < m_total; i++) m_bits[i] = job_bytes[i/8][7-(i%8)];
        last = 0;
        cnt = 0;
        m_cum[0] = 0;
        m_hit[0] = 1'b0;
        for (int k = 1; k <= m_total; k++) begin
            ok = (k >= PAT_W) && (ovl || (k - last >= PAT_W));
            if (ok) begin
                for (int j = 0; j < PAT_W; j++) begin
                    if (m_bits[k-PAT_W+j] != pat[PAT_W-1-j]) ok = 1'b0;
                end
            end
            m_hit[k] = ok;
            if (ok) begin
                last = k;
                if (cnt < CMAX) cnt++;
            end
            m_cum[k] = cnt;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            mon_shift = bus.o_busy && !bus.o_in_ready;
            chk("match", bus.o_match, last_shift && m_hit[n]);
            if (bus.o_match) pulses++;
            chk("match_cnt", bus.o_match_cnt, m_cum[n]);
            mon_exp_done = zero_pend || (last_shift && (n == m_total) && (m_total > 0));
            zero_pend = 1'b0;
            chk("done", bus.o_done, mon_exp_done);
            if (bus.o_in_ready) ready_seen = 1'b1;
            if (mon_shift) begin
                lo_run++;
                if (n < m_total) begin
                    chk("bit_out", bus.o_bit_out, m_bits[n]);
                    n++;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL extra_bit: shifted bit %0d, job has only %0d at %0t",
                             n + 1, m_total, $time);
                end
            end else begin
                chk("bit_out_idle", bus.o_bit_out, 1'b0);
                if (bus.o_in_ready) begin
                    if (lo_run > 0) gap_seen = lo_run;
                    lo_run = 0;
                end
            end
            last_shift = mon_shift;
        end
    end

    task automatic send_byte(input logic [7:0] data, input int gap);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.o_in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready=0 expected 1 at %0t", $time);
        end
        repeat (gap) @(negedge clk);
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = data;
        @(posedge clk);
        #1;
        bus.i_in_valid = 1'b0;
    endtask

    task automatic start_job(input logic [PAT_W-1:0] pat, input bit ovl);
        @(posedge clk);
        #1;
        bus.i_start       = 1'b1;
        bus.i_num_bytes   = 8'(job_bytes.size());
        bus.i_cfg_pattern = pat;
        bus.i_cfg_overlap = ovl;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        build_model(pat, ovl);
        n = 0;
        last_shift = 1'b0;
        pulses = 0;
        lo_run = 0;
        gap_seen = 0;
        ready_seen = 1'b0;
        zero_pend = (job_bytes.size() == 0);
    endtask

    task automatic run_job(input logic [PAT_W-1:0] pat, input bit ovl, input int gap);
        bit got;
        start_job(pat, ovl);
        foreach (job_bytes[b]) send_byte(job_bytes[b], gap);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.o_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=0 expected 1 at %0t", $time);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.i_start       = 1'b0;
        bus.i_num_bytes   = 8'd0;
        bus.i_cfg_pattern = '0;
        bus.i_cfg_overlap = 1'b0;
        bus.i_in_data     = 8'd0;
        bus.i_in_valid    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_ready", bus.o_in_ready, 1'b0);
        chk("rst_done", bus.o_done, 1'b0);
        chk("rst_cnt", bus.o_match_cnt, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // 1: 1010 overlapping over 0xAA
        job_bytes = '{8'hAA};
        run_job(4'b1010, 1'b1, 0);
        chk("t1_model_hits", m_cum[8], 3);
        chk("t1_pulses", pulses, 3);
        chk("t1_cnt", bus.o_match_cnt, 3);

        // 2: non-overlapping
        run_job(4'b1010, 1'b0, 0);
        chk("t2_pulses", pulses, 2);
        chk("t2_cnt", bus.o_match_cnt, 2);

        // 3: match spans byte boundary
        job_bytes = '{8'h01, 8'h40};
        run_job(4'b1010, 1'b1, 0);
        chk("t3_pulses", pulses, 1);
        chk("t3_cnt", bus.o_match_cnt, 1);
        chk("t3_ready_gap", gap_seen, 8);

        // 4: empty job
        job_bytes = {};
        run_job(4'b1010, 1'b1, 0);
        chk("t4_cnt", bus.o_match_cnt, 0);
        chk("t4_ready_seen", ready_seen, 1'b0);

        // 5: saturation with in_valid stalls
        job_bytes = {};
        for (int i = 0; i < 40; i++) job_bytes.push_back(8'h00);
        run_job(4'b0000, 1'b1, 2);
        chk("t5_model_cnt", m_cum[320], 255);
        chk("t5_cnt", bus.o_match_cnt, 255);
        chk("t5_pulses", pulses, 317);

        // 6: reset mid-SHIFT, then a clean job with an ignored start while busy
        job_bytes = '{8'hFF, 8'h12};
        start_job(4'b1111, 1'b1);
        send_byte(8'hFF, 0);
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", bus.o_busy, 1'b0);
        chk("t6_bit", bus.o_bit_out, 1'b0);
        chk("t6_match", bus.o_match, 1'b0);
        chk("t6_cnt", bus.o_match_cnt, 0);
        chk("t6_done", bus.o_done, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_done_rst", bus.o_done, 1'b0);
        end
        rst_n = 1'b1;
        job_bytes = {};
        m_total = 0;
        m_cum[0] = 0;
        m_hit[0] = 1'b0;
        n = 0;
        last_shift = 1'b0;
        zero_pend = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_idle_busy", bus.o_busy, 1'b0);

        job_bytes = '{8'hAA};
        fork
            run_job(4'b1010, 1'b1, 0);
            begin
                repeat (5) @(posedge clk);
                #2;
                bus.i_start       = 1'b1;
                bus.i_num_bytes   = 8'd0;
                bus.i_cfg_pattern = 4'b1111;
                @(posedge clk);
                #2;
                bus.i_start = 1'b0;
            end
        join
        chk("t6_pulses", pulses, 3);
        chk("t6_cnt", bus.o_match_cnt, 3);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
